// File: rtl/pc_seq_if.sv
// Bundle between a program-counter sequencer and its controller / return-address stack.
// The controller side (master) drives control, flags, target and stack top; the sequencer (slave) drives pc and stack strobes.
interface pc_seq_if #(
    parameter int ADDR_W = 11
);
    logic              stall;
    logic              jump;
    logic              branch;
    logic [1:0]        cond;
    logic              flag_zero;
    logic              flag_carry;
    logic              call;
    logic              ret;
    logic              halt;
    logic              resume;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pop_data;
    logic [ADDR_W-1:0] pc;
    logic              push_enable;
    logic [ADDR_W-1:0] push_data;
    logic              pop_enable;
    logic [5:0]        depth;
    logic              halted;
    logic              fault;

    modport master (
        output stall, jump, branch, cond, flag_zero, flag_carry,
        output call, ret, halt, resume, target, pop_data,
        input  pc, push_enable, push_data, pop_enable, depth, halted, fault
    );

    modport slave (
        input  stall, jump, branch, cond, flag_zero, flag_carry,
        input  call, ret, halt, resume, target, pop_data,
        output pc, push_enable, push_data, pop_enable, depth, halted, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with next-address selection (increment/jump/branch/call/return), halt control,
// and a mirrored return-stack depth that turns overflow/underflow into a sticky fault.
module pc_sequencer #(
    parameter int ADDR_W       = 11,
    parameter int STACK_DEPTH  = 32,
    parameter int RESET_VECTOR = 0
) (
    input  logic     clk,
    input  logic     rst,
    pc_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01,
        ST_FAULT  = 2'b10
    } state_t;

    localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_VECTOR);
    localparam logic [5:0]        DEPTH_MAX = 6'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [5:0]        depth_r;
    logic [5:0]        depth_nxt_s;
    logic              push_s;
    logic              pop_s;

    function automatic logic cond_met(input logic [1:0] cond, input logic z, input logic c);
        case (cond)
            2'b00:   return 1'b1;
            2'b01:   return z;
            2'b10:   return c;
            2'b11:   return ~z;
            default: return 1'b0;
        endcase
    endfunction

    assign pc_inc_s = pc_r + PC_ONE;

    // Next-state, next-pc, depth and stack strobe selection.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        depth_nxt_s = depth_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.stall) begin
                    state_nxt_s = ST_RUN;
                end else if (bus.ret) begin
                    // Underflow faults without touching pc or the stack.
                    if (depth_r == 6'd0) begin
                        state_nxt_s = ST_FAULT;
                    end else begin
                        pop_s       = 1'b1;
                        pc_nxt_s    = bus.pop_data;
                        depth_nxt_s = depth_r - 6'd1;
                    end
                end else if (bus.call) begin
                    if (depth_r == DEPTH_MAX) begin
                        state_nxt_s = ST_FAULT;
                    end else begin
                        push_s      = 1'b1;
                        pc_nxt_s    = bus.target;
                        depth_nxt_s = depth_r + 6'd1;
                    end
                end else if (bus.jump) begin
                    pc_nxt_s = bus.target;
                end else if (bus.branch) begin
                    if (cond_met(bus.cond, bus.flag_zero, bus.flag_carry)) begin
                        pc_nxt_s = bus.target;
                    end else begin
                        pc_nxt_s = pc_inc_s;
                    end
                end else if (bus.halt) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    pc_nxt_s = pc_inc_s;
                end
            end
            ST_HALTED: begin
                if (bus.resume && !bus.stall) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            ST_FAULT: begin
                state_nxt_s = ST_FAULT;
            end
            default: begin
                state_nxt_s = ST_FAULT;
            end
        endcase
    end

    // State, pc and depth registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            pc_r    <= RST_PC;
            depth_r <= 6'd0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            depth_r <= depth_nxt_s;
        end
    end

    // Strobes are suppressed while rst is held so the stack sees no stray push/pop.
    assign bus.pc          = pc_r;
    assign bus.push_enable = push_s & ~rst;
    assign bus.pop_enable  = pop_s & ~rst;
    assign bus.push_data   = pc_inc_s;
    assign bus.depth       = depth_r;
    assign bus.halted      = (state_r == ST_HALTED);
    assign bus.fault       = (state_r == ST_FAULT);

endmodule
